// File: rtl/deser_pkg.sv
// Shared definitions for the 8x32 deserialiser cell and its frame controller.
package deser_pkg;

  localparam int WORD_W         = 32;
  localparam int NUM_WORDS      = 8;
  localparam int FRAME_BITS_DEF = WORD_W * NUM_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/deser_sync_detect.sv
// Sync-word hunter: serial history register plus comparator against SYNC_WORD.
module deser_sync_detect
  import deser_pkg::*;
#(
  parameter int                  SYNC_LEN  = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 8'hA5
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLR,
  input  logic SERIAL_IN,
  output logic MATCH
);

  // Only SYNC_LEN-1 past bits are kept: the oldest bit of a full-length
  // register would already have been shifted out when the comparison is made.
  logic [SYNC_LEN-2:0] hist_p1;
  logic [SYNC_LEN-1:0] window;

  assign window = {hist_p1, SERIAL_IN};
  assign MATCH  = (window == SYNC_WORD);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hist_p1 <= '0;
    end else if (CLR) begin
      hist_p1 <= '0;
    end else begin
      hist_p1 <= window[SYNC_LEN-2:0];
    end
  end

endmodule

// File: rtl/deser_frame_ctrl.sv
// Frame sequencer for the deserialiser cell: sync hunt, READY gating,
// frame-valid/ack handshake, watchdog, frame counter and sticky errors.
module deser_frame_ctrl
  import deser_pkg::*;
#(
  parameter int                  SYNC_LEN   = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD  = 8'hA5,
  parameter int                  FRAME_BITS = FRAME_BITS_DEF,
  parameter int                  TIMEOUT    = 300,
  parameter int                  CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             SERIAL_IN,
  input  logic             CELL_COMPLETE,
  output logic             READY,
  output logic             FRAME_VALID,
  input  logic             FRAME_ACK,
  output logic [CNT_W-1:0] FRAME_COUNT,
  output logic [8:0]       BIT_COUNT,
  output logic             TIMEOUT_ERR,
  output logic             OVERRUN_ERR,
  output logic [1:0]       STATE
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [8:0]      BIT_MAX = 9'(FRAME_BITS);

  state_t           state_r, state_d;
  logic             complete_p1;
  logic             match, sync_clr;
  logic             rise, wd_exp, ack;
  logic [WD_W-1:0]  wd_r;
  logic [8:0]       bit_cnt_r;
  logic [CNT_W-1:0] frame_cnt_r;
  logic             fv_r, timeout_err_r, overrun_err_r;

  function automatic logic [8:0] bit_cnt_sat_inc(input logic [8:0] v);
    return (v >= BIT_MAX) ? BIT_MAX : v + 9'd1;
  endfunction

  // The history register keeps shifting outside IDLE, so a sync word that
  // arrives while a frame is still being handed over is caught immediately.
  assign sync_clr = (state_r == ST_IDLE);

  deser_sync_detect #(
    .SYNC_LEN  (SYNC_LEN),
    .SYNC_WORD (SYNC_WORD)
  ) u_sync (
    .CLK       (CLK),
    .RESET     (RESET),
    .CLR       (sync_clr),
    .SERIAL_IN (SERIAL_IN),
    .MATCH     (match)
  );

  assign rise   = CELL_COMPLETE & ~complete_p1;
  assign wd_exp = (wd_r == WD_LAST);
  assign ack    = ENABLE && (state_r == ST_HOLD) && fv_r && FRAME_ACK;

  always_comb begin
    state_d = state_r;
    if (!ENABLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_d = ST_HUNT;
        ST_HUNT: if (match) state_d = ST_RUN;
        ST_RUN: begin
          if (rise)        state_d = ST_HOLD;
          else if (wd_exp) state_d = ST_HUNT;
        end
        ST_HOLD: if (ack) state_d = ST_HUNT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r     <= ST_IDLE;
      complete_p1 <= 1'b0;
    end else begin
      state_r     <= state_d;
      complete_p1 <= CELL_COMPLETE;
    end
  end

  // Watchdog only counts while the frame stays in RUN; any exit rearms it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wd_r <= '0;
    end else if (state_r == ST_RUN && state_d == ST_RUN) begin
      wd_r <= wd_r + WD_W'(1);
    end else begin
      wd_r <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bit_cnt_r <= '0;
    end else if (ENABLE) begin
      case (state_r)
        ST_HUNT: bit_cnt_r <= '0;
        ST_RUN:  bit_cnt_r <= (wd_exp && !rise) ? 9'd0 : bit_cnt_sat_inc(bit_cnt_r);
        ST_HOLD: if (ack) bit_cnt_r <= '0;
        default: bit_cnt_r <= bit_cnt_r;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fv_r          <= 1'b0;
      frame_cnt_r   <= '0;
      timeout_err_r <= 1'b0;
      overrun_err_r <= 1'b0;
    end else begin
      fv_r <= ENABLE && (state_r == ST_HOLD) && !ack;
      if (ack) frame_cnt_r <= frame_cnt_r + CNT_W'(1);
      if (ENABLE && state_r == ST_RUN && wd_exp && !rise) timeout_err_r <= 1'b1;
      if (ENABLE && state_r == ST_HOLD && rise) overrun_err_r <= 1'b1;
    end
  end

  assign READY       = (state_r == ST_RUN) || (state_r == ST_HOLD);
  assign FRAME_VALID = fv_r;
  assign FRAME_COUNT = frame_cnt_r;
  assign BIT_COUNT   = bit_cnt_r;
  assign TIMEOUT_ERR = timeout_err_r;
  assign OVERRUN_ERR = overrun_err_r;
  assign STATE       = state_r;

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// Directed bench for deser_frame_ctrl with a behavioural 256-bit cell model.
module tb_deser_frame_ctrl;

  logic        CLK, RESET, ENABLE, SERIAL_IN, CELL_COMPLETE, FRAME_ACK;
  logic        READY, FRAME_VALID, TIMEOUT_ERR, OVERRUN_ERR;
  logic [15:0] FRAME_COUNT;
  logic [8:0]  BIT_COUNT;
  logic [1:0]  STATE;

  int vecs = 0;
  int errs = 0;

  logic       cell_en, cell_gap;
  logic [8:0] cell_cnt;

  deser_frame_ctrl dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ENABLE        (ENABLE),
    .SERIAL_IN     (SERIAL_IN),
    .CELL_COMPLETE (CELL_COMPLETE),
    .READY         (READY),
    .FRAME_VALID   (FRAME_VALID),
    .FRAME_ACK     (FRAME_ACK),
    .FRAME_COUNT   (FRAME_COUNT),
    .BIT_COUNT     (BIT_COUNT),
    .TIMEOUT_ERR   (TIMEOUT_ERR),
    .OVERRUN_ERR   (OVERRUN_ERR),
    .STATE         (STATE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Cell model: counts bits clocked while READY=1, COMPLETE once 256 are in.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET)                cell_cnt <= 9'd0;
    else if (!READY)           cell_cnt <= 9'd0;
    else if (cell_cnt < 9'd256) cell_cnt <= cell_cnt + 9'd1;
  end
  assign CELL_COMPLETE = cell_en && !cell_gap && (cell_cnt == 9'd256);

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic tick(input logic b);
    SERIAL_IN = b;
    @(negedge CLK);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tick(v[i]);
  endtask

  // 0x00 then the sync word, issued while already in HUNT.
  task automatic hunt();
    send_bits(16'h00A5, 16);
  endtask

  task automatic test_reset();
    RESET = 1'b0; ENABLE = 1'b0; SERIAL_IN = 1'b0; FRAME_ACK = 1'b0;
    cell_en = 1'b1; cell_gap = 1'b0;
    @(negedge CLK); @(negedge CLK);
    vecs++; if ({STATE, READY, FRAME_VALID, TIMEOUT_ERR, OVERRUN_ERR} !== 6'b0) begin
      errs++; $display("FAIL reset_ctrl: got %b want 000000", {STATE, READY, FRAME_VALID, TIMEOUT_ERR, OVERRUN_ERR}); end
    vecs++; if ({FRAME_COUNT, BIT_COUNT} !== 25'd0) begin
      errs++; $display("FAIL reset_counts: got fc=%0d bc=%0d want 0/0", FRAME_COUNT, BIT_COUNT); end
    RESET = 1'b1;
    tick(1'b0); tick(1'b0);
    vecs++; if (STATE !== 2'd0) begin
      errs++; $display("FAIL idle_disabled: got state %0d want 0", STATE); end
  endtask

  task automatic test_basic_frame();
    ENABLE = 1'b1;
    send_bits(16'h0052, 15);
    vecs++; if (STATE !== 2'd1 || READY !== 1'b0) begin
      errs++; $display("FAIL pre_sync: got state %0d ready %b want 1/0", STATE, READY); end
    tick(1'b1);
    vecs++; if (STATE !== 2'd2 || READY !== 1'b1 || BIT_COUNT !== 9'd0) begin
      errs++; $display("FAIL sync_ready: got state %0d ready %b bc %0d want 2/1/0", STATE, READY, BIT_COUNT); end
    repeat (256) tick(1'b1);
    vecs++; if (BIT_COUNT !== 9'd256 || FRAME_VALID !== 1'b0 || STATE !== 2'd2) begin
      errs++; $display("FAIL payload_done: got bc %0d fv %b state %0d want 256/0/2", BIT_COUNT, FRAME_VALID, STATE); end
    tick(1'b0);
    vecs++; if (STATE !== 2'd3 || FRAME_VALID !== 1'b0 || READY !== 1'b1) begin
      errs++; $display("FAIL hold_entry: got state %0d fv %b ready %b want 3/0/1", STATE, FRAME_VALID, READY); end
    tick(1'b0);
    vecs++; if (FRAME_VALID !== 1'b1) begin
      errs++; $display("FAIL fv_latency: got fv %b want 1", FRAME_VALID); end
    FRAME_ACK = 1'b1;
    tick(1'b0);
    FRAME_ACK = 1'b0;
    vecs++; if (FRAME_VALID !== 1'b0 || FRAME_COUNT !== 16'd1 || READY !== 1'b0 || STATE !== 2'd1 || BIT_COUNT !== 9'd0) begin
      errs++; $display("FAIL ack_basic: got fv %b fc %0d ready %b state %0d bc %0d want 0/1/0/1/0",
                       FRAME_VALID, FRAME_COUNT, READY, STATE, BIT_COUNT); end
  endtask

  task automatic test_timeout();
    cell_en = 1'b0;
    hunt();
    repeat (299) tick(1'b0);
    vecs++; if (READY !== 1'b1 || TIMEOUT_ERR !== 1'b0 || STATE !== 2'd2) begin
      errs++; $display("FAIL wd_before: got ready %b terr %b state %0d want 1/0/2", READY, TIMEOUT_ERR, STATE); end
    tick(1'b0);
    vecs++; if (READY !== 1'b0 || TIMEOUT_ERR !== 1'b1 || STATE !== 2'd1 || BIT_COUNT !== 9'd0) begin
      errs++; $display("FAIL wd_expire: got ready %b terr %b state %0d bc %0d want 0/1/1/0", READY, TIMEOUT_ERR, STATE, BIT_COUNT); end
    tick(1'b0);
    cell_en = 1'b1;
    hunt();
    repeat (256) tick(1'b1);
    tick(1'b0); tick(1'b0);
    vecs++; if (FRAME_VALID !== 1'b1) begin
      errs++; $display("FAIL recover_fv: got fv %b want 1", FRAME_VALID); end
    FRAME_ACK = 1'b1;
    tick(1'b0);
    FRAME_ACK = 1'b0;
    vecs++; if (FRAME_COUNT !== 16'd2 || TIMEOUT_ERR !== 1'b1) begin
      errs++; $display("FAIL recover_count: got fc %0d terr %b want 2/1", FRAME_COUNT, TIMEOUT_ERR); end
  endtask

  task automatic test_overrun();
    hunt();
    repeat (256) tick(1'b1);
    tick(1'b0); tick(1'b0);
    repeat (1000) tick(1'b0);
    vecs++; if (FRAME_VALID !== 1'b1 || STATE !== 2'd3 || OVERRUN_ERR !== 1'b0) begin
      errs++; $display("FAIL hold_wait: got fv %b state %0d oerr %b want 1/3/0", FRAME_VALID, STATE, OVERRUN_ERR); end
    cell_gap = 1'b1;
    tick(1'b0);
    cell_gap = 1'b0;
    tick(1'b0);
    vecs++; if (OVERRUN_ERR !== 1'b1 || FRAME_VALID !== 1'b1 || STATE !== 2'd3) begin
      errs++; $display("FAIL overrun: got oerr %b fv %b state %0d want 1/1/3", OVERRUN_ERR, FRAME_VALID, STATE); end
    FRAME_ACK = 1'b1;
    tick(1'b0);
    FRAME_ACK = 1'b0;
    vecs++; if (STATE !== 2'd1 || FRAME_COUNT !== 16'd3) begin
      errs++; $display("FAIL overrun_ack: got state %0d fc %0d want 1/3", STATE, FRAME_COUNT); end
  endtask

  task automatic test_enable_drop();
    hunt();
    send_bits(16'h00A5, 8);
    vecs++; if (STATE !== 2'd2 || BIT_COUNT !== 9'd8) begin
      errs++; $display("FAIL overlap_run: got state %0d bc %0d want 2/8", STATE, BIT_COUNT); end
    ENABLE = 1'b0;
    tick(1'b0);
    vecs++; if (STATE !== 2'd0 || READY !== 1'b0 || BIT_COUNT !== 9'd8) begin
      errs++; $display("FAIL en_drop: got state %0d ready %b bc %0d want 0/0/8", STATE, READY, BIT_COUNT); end
    ENABLE = 1'b1;
    tick(1'b0);
    vecs++; if (STATE !== 2'd1 || READY !== 1'b0 || FRAME_COUNT !== 16'd3 || {TIMEOUT_ERR, OVERRUN_ERR} !== 2'b11) begin
      errs++; $display("FAIL en_restore: got state %0d ready %b fc %0d errs %b want 1/0/3/11",
                       STATE, READY, FRAME_COUNT, {TIMEOUT_ERR, OVERRUN_ERR}); end
  endtask

  task automatic test_reset_midrun();
    logic seen_fv, seen_run;
    hunt();
    repeat (100) tick(1'b1);
    vecs++; if (BIT_COUNT !== 9'd100) begin
      errs++; $display("FAIL midrun_bc: got %0d want 100", BIT_COUNT); end
    #1 RESET = 1'b0;
    #1;
    vecs++; if ({STATE, READY, FRAME_VALID, TIMEOUT_ERR, OVERRUN_ERR} !== 6'b0 || {FRAME_COUNT, BIT_COUNT} !== 25'd0) begin
      errs++; $display("FAIL async_reset: got ctrl %b fc %0d bc %0d want 0/0/0",
                       {STATE, READY, FRAME_VALID, TIMEOUT_ERR, OVERRUN_ERR}, FRAME_COUNT, BIT_COUNT); end
    @(negedge CLK);
    RESET = 1'b1;
    seen_fv = 1'b0; seen_run = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b0);
      seen_fv  = seen_fv | FRAME_VALID;
      seen_run = seen_run | (STATE == 2'd2);
    end
    vecs++; if (seen_fv !== 1'b0 || seen_run !== 1'b0) begin
      errs++; $display("FAIL post_reset_quiet: got fv_seen %b run_seen %b want 0/0", seen_fv, seen_run); end
  endtask

  // Next sync straddles the handover: its last bit lands one edge after ACK.
  task automatic test_back_to_back();
    hunt();
    for (int f = 0; f < 3; f++) begin
      repeat (252) tick(1'b0);
      send_bits(16'h000A, 4);
      tick(1'b0);
      tick(1'b1);
      vecs++; if (FRAME_VALID !== 1'b1) begin
        errs++; $display("FAIL b2b_fv%0d: got %b want 1", f, FRAME_VALID); end
      FRAME_ACK = 1'b1;
      tick(1'b0);
      FRAME_ACK = 1'b0;
      vecs++; if (READY !== 1'b0 || STATE !== 2'd1 || FRAME_COUNT !== 16'(f + 1)) begin
        errs++; $display("FAIL b2b_ack%0d: got ready %b state %0d fc %0d want 0/1/%0d", f, READY, STATE, FRAME_COUNT, f + 1); end
      if (f < 2) begin
        tick(1'b1);
        vecs++; if (READY !== 1'b1 || STATE !== 2'd2) begin
          errs++; $display("FAIL b2b_rearm%0d: got ready %b state %0d want 1/2", f, READY, STATE); end
      end else begin
        tick(1'b0);
        vecs++; if (STATE !== 2'd1 || READY !== 1'b0) begin
          errs++; $display("FAIL b2b_last: got state %0d ready %b want 1/0", STATE, READY); end
      end
    end
    vecs++; if (FRAME_COUNT !== 16'd3 || {TIMEOUT_ERR, OVERRUN_ERR} !== 2'b00) begin
      errs++; $display("FAIL b2b_final: got fc %0d errs %b want 3/00", FRAME_COUNT, {TIMEOUT_ERR, OVERRUN_ERR}); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_timeout();
    test_overrun();
    test_enable_drop();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
